mod_reduce_seq: RTL

MOD_REDUCE_SEQ -- requirements
Module: mod_reduce_seq

---
 rtl/mulmod_pkg.sv | 25 ++
 rtl/csub65.sv | 22 ++
 rtl/mod_reduce_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mulmod_pkg.sv
// Shared widths, FSM state encoding and iteration counts for the modular reducer.
// Latency: n/a (package).
// Backpressure: n/a. Build option MODRED_RADIX4_EN selects two remainder bits per cycle.
package mulmod_pkg;

    localparam int P_WIDTH  = 64;
    localparam int PD_WIDTH = 2 * P_WIDTH;

    // RUN-cycle counts for one full product, one per radix build
    localparam int ITER_RADIX2 = PD_WIDTH;
    localparam int ITER_RADIX4 = PD_WIDTH / 2;

`ifdef MODRED_RADIX4_EN
    localparam int ITER_COUNT = ITER_RADIX4;
`else
    localparam int ITER_COUNT = ITER_RADIX2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csub65.sv
// Conditional subtract: r_out = (r_in >= n_in) ? r_in - n_in : r_in, ge flags the subtract.
// Latency: combinational.
// Backpressure: none (pure datapath).
module csub65 #(
    parameter int W = 65
) (
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] n_in,
    output logic [W-1:0] r_out,
    output logic         ge
);

    logic [W:0] sum;

    // Single adder r + ~n + 1; its carry-out is the r >= n comparison
    always_comb begin
        sum   = {1'b0, r_in} + {1'b0, ~n_in} + {{W{1'b0}}, 1'b1};
        ge    = sum[W];
        r_out = sum[W] ? sum[W-1:0] : r_in;
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// Bit-serial restoring reduction Res_out = Mul_in mod N_in, MSB first (MODRED_RADIX4_EN: 2 bits/cycle).
// Latency: result valid after PD_WIDTH edges (PD_WIDTH/2 radix-4) past accept; N_in==0 after one edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle bypass.
module mod_reduce_seq #(
    parameter int P_WIDTH  = mulmod_pkg::P_WIDTH,
    parameter int PD_WIDTH = mulmod_pkg::PD_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PD_WIDTH-1:0] Mul_in,
    input  logic [P_WIDTH-1:0]  N_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_WIDTH-1:0]  Res_out,
    output logic                err_out,
    output logic                busy
);

    import mulmod_pkg::*;

    // Iteration count scales with the product width relative to the package default
    localparam int N_ITER = ITER_COUNT * PD_WIDTH / mulmod_pkg::PD_WIDTH;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int RW     = P_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    state_t               state_q, state_d;
    logic [PD_WIDTH-1:0]  sh_q, sh_d;
    logic [P_WIDTH-1:0]   n_q, n_d;
    // Remainder is always < N between cycles, so only P_WIDTH bits need storing;
    // the 65-bit working value exists only inside the step below.
    logic [P_WIDTH-1:0]   r_q, r_d;
    logic [P_WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;

    logic [RW-1:0]        n_ext;
    logic [RW-1:0]        ra_in, ra_out;
    logic                 ge_a;
    logic [P_WIDTH-1:0]   r_step;
    logic [PD_WIDTH-1:0]  sh_step;
    logic                 unused_csub;

    assign n_ext = {1'b0, n_q};
    assign ra_in = {r_q, sh_q[PD_WIDTH-1]};

    csub65 #(.W(RW)) u_csub_a (
        .r_in  (ra_in),
        .n_in  (n_ext),
        .r_out (ra_out),
        .ge    (ge_a)
    );

`ifdef MODRED_RADIX4_EN
    logic [RW-1:0] rb_in, rb_out;
    logic          ge_b;

    // Second bit of the pair: shift the first partial remainder and subtract again
    assign rb_in = {ra_out[P_WIDTH-1:0], sh_q[PD_WIDTH-2]};

    csub65 #(.W(RW)) u_csub_b (
        .r_in  (rb_in),
        .n_in  (n_ext),
        .r_out (rb_out),
        .ge    (ge_b)
    );

    assign r_step      = rb_out[P_WIDTH-1:0];
    assign sh_step     = {sh_q[PD_WIDTH-3:0], 2'b00};
    // Top bit of each partial remainder is zero after the subtract
    assign unused_csub = ^{ge_a, ge_b, ra_out[RW-1], rb_out[RW-1]};
`else
    assign r_step      = ra_out[P_WIDTH-1:0];
    assign sh_step     = {sh_q[PD_WIDTH-2:0], 1'b0};
    assign unused_csub = ^{ge_a, ra_out[RW-1]};
`endif

    // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE until taken
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        n_d     = n_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sh_d    = Mul_in;
                    n_d     = N_in;
                    r_d     = '0;
                    cnt_d   = '0;
                    res_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (n_q == '0) begin
                    // Zero modulus: skip iterating, flag the error straight away
                    err_d   = 1'b1;
                    res_d   = '0;
                    vld_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    sh_d  = sh_step;
                    r_d   = r_step;
                    // Counter stops at N_ITER; it never wraps back to zero in RUN
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        res_d   = r_step;
                        vld_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = vld_q;
    assign Res_out   = res_q;
    assign err_out   = err_q;

endmodule
